// File: rtl/b_syn_updown.sv
// Parametrised synchronous up/down counter with load, enable, saturate-or-wrap
// mode, combinational terminal count and a registered boundary-step pulse.
module b_syn_updown #(
  parameter int          WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 15,
  parameter int unsigned RST_VAL  = 15,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             re,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] c,
  output logic             tc,
  output logic             wrap
);

  // Reject parameter sets the counter cannot represent.
  if (WIDTH < 1 || WIDTH > 32) begin : gen_bad_width
    $error("b_syn_updown: WIDTH must be in 1..32");
  end
  if (MAX_VAL < 1 || 64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : gen_bad_max
    $error("b_syn_updown: MAX_VAL must be in 1..2^WIDTH-1");
  end
  if (RST_VAL > MAX_VAL) begin : gen_bad_rst
    $error("b_syn_updown: RST_VAL must not exceed MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             atMax, atZero;

  assign atMax  = (count_q == MAX_W);
  assign atZero = (count_q == ZERO_W);
  assign tc     = up ? atMax : atZero;

  // Boundary tests come before the step, so MAX_VAL = 2^WIDTH-1 never needs a carry bit.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (ld) begin
      count_d = (d > MAX_W) ? MAX_W : d;
    end else if (en) begin
      wrap_d = tc;
      if (up) begin
        if (!atMax) begin
          count_d = count_q + ONE_W;
        end else if (!SATURATE) begin
          count_d = ZERO_W;
        end
      end else begin
        if (!atZero) begin
          count_d = count_q - ONE_W;
        end else if (!SATURATE) begin
          count_d = MAX_W;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge re) begin
    if (re) begin
      count_q <= RST_W;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign c    = count_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_b_syn_updown.sv
// Randomised and directed bench for b_syn_updown: three configurations share the
// same stimulus and are compared against an arithmetic reference model.
module tb_b_syn_updown;

  logic       clk;
  logic       re;
  logic       en;
  logic       up;
  logic       ld;
  logic [3:0] d;

  logic [3:0] c0, c1, c2;
  logic       tc0, tc1, tc2;
  logic       w0, w1, w2;

  int checks;
  int errors;

  // Configurations: 0 = defaults, 1 = modulus 10, 2 = saturating.
  int maxV[3] = '{15, 9, 15};
  int rstV[3] = '{15, 9, 15};
  int satV[3] = '{0, 0, 1};
  int mCount[3];
  int mWrap[3];

  b_syn_updown dut0 (
    .clk(clk), .re(re), .en(en), .up(up), .ld(ld), .d(d),
    .c(c0), .tc(tc0), .wrap(w0)
  );

  b_syn_updown #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(9), .SATURATE(1'b0)) dut1 (
    .clk(clk), .re(re), .en(en), .up(up), .ld(ld), .d(d),
    .c(c1), .tc(tc1), .wrap(w1)
  );

  b_syn_updown #(.WIDTH(4), .MAX_VAL(15), .RST_VAL(15), .SATURATE(1'b1)) dut2 (
    .clk(clk), .re(re), .en(en), .up(up), .ld(ld), .d(d),
    .c(c2), .tc(tc2), .wrap(w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int obsCount(input int i);
    case (i)
      0:       return int'(c0);
      1:       return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  function automatic int obsWrap(input int i);
    case (i)
      0:       return int'(w0);
      1:       return int'(w1);
      default: return int'(w2);
    endcase
  endfunction

  function automatic int obsTc(input int i);
    case (i)
      0:       return int'(tc0);
      1:       return int'(tc1);
      default: return int'(tc2);
    endcase
  endfunction

  function automatic int modelTc(input int i, input logic dirUp);
    return dirUp ? int'(mCount[i] == maxV[i]) : int'(mCount[i] == 0);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mCount[i] = rstV[i];
      mWrap[i]  = 0;
    end
  endtask

  // One clock edge of the reference behaviour, using plain modular arithmetic.
  task automatic modelStep(input logic sEn, input logic sUp, input logic sLd, input int sD);
    for (int i = 0; i < 3; i++) begin
      int atLimit;
      if (sLd) begin
        mCount[i] = (sD > maxV[i]) ? maxV[i] : sD;
        mWrap[i]  = 0;
      end else if (sEn) begin
        atLimit  = modelTc(i, sUp);
        mWrap[i] = atLimit;
        if (!(satV[i] == 1 && atLimit == 1)) begin
          if (sUp) mCount[i] = (mCount[i] + 1) % (maxV[i] + 1);
          else     mCount[i] = (mCount[i] + maxV[i]) % (maxV[i] + 1);
        end
      end else begin
        mWrap[i] = 0;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s c[%0d]", tag, i), obsCount(i), mCount[i]);
      checkOutput($sformatf("%s wrap[%0d]", tag, i), obsWrap(i), mWrap[i]);
    end
  endtask

  // Drive one cycle's inputs, check tc combinationally, then check the edge result.
  task automatic applyStimulus(input logic sEn, input logic sUp, input logic sLd,
                               input int sD, input string tag);
    en = sEn;
    up = sUp;
    ld = sLd;
    d  = 4'(sD);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s tc[%0d]", tag, i), obsTc(i), modelTc(i, sUp));
    end
    @(posedge clk);
    modelStep(sEn, sUp, sLd, sD);
    #1;
    checkAll(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    re = 1'b1;
    en = 1'b0;
    up = 1'b0;
    ld = 1'b0;
    d  = 4'd0;
    modelReset();

    #23;
    checkAll("reset");
    @(negedge clk);
    re = 1'b0;

    applyStimulus(1, 0, 0, 0, "rel1");
    applyStimulus(1, 0, 0, 0, "rel2");

    applyStimulus(0, 0, 1, 1, "ldOne");
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, "downWrap");

    applyStimulus(0, 1, 1, 8, "ldEight");
    for (int k = 0; k < 3; k++) applyStimulus(1, 1, 0, 0, "upWrap");

    applyStimulus(0, 1, 1, 14, "ldFourteen");
    for (int k = 0; k < 4; k++) applyStimulus(1, 1, 0, 0, "saturate");

    applyStimulus(1, 1, 1, 12, "ldClamp");
    applyStimulus(1, 0, 0, 0, "afterClamp");

    applyStimulus(0, 0, 1, 5, "ldFive");
    for (int k = 0; k < 4; k++) applyStimulus(1, (k % 2) == 0, 0, 0, "flip");
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0, "hold");

    // Async reset mid-cycle right after a boundary step left wrap high.
    applyStimulus(0, 0, 1, 0, "ldZero");
    applyStimulus(1, 0, 0, 0, "preReset");
    #2;
    re = 1'b1;
    #1;
    modelReset();
    checkAll("asyncReset");
    @(posedge clk);
    #1;
    checkAll("resetHeld");
    @(negedge clk);
    re = 1'b0;
    applyStimulus(1, 0, 1, 3, "resetLdPrio");
    applyStimulus(1, 0, 0, 0, "resume");

    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
